ttt_ps2_keys: RTL and testbench

PS/2 keyboard front end for the tic-tac-toe game. It receives PS/2 device-to-host frames, decodes set-2 make/break codes, and drives six held-key level outputs (up, down, left, right, enter, space). These outputs feed the game controller's key inputs directly; the controller does its own synchronisation and edge detection. Runs on the 25 MHz game clock. Host-to-device transmission is out of scope.

---
 rtl/ttt_ps2_keys_if.sv | 27 ++
 rtl/ttt_ps2_keys.sv | 215 +++++++++++++++++++++
 tb/tb_ttt_ps2_keys.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ttt_ps2_keys_if.sv
// Signal bundle between the PS/2 connector, the key front end and the game controller.
// The slave side is the front end; the master side drives the raw PS/2 lines.
interface ttt_ps2_keys_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       enter;
    logic       space;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    modport slave (
        input  ps2_clk, ps2_data,
        output up, down, left, right, enter, space,
        output scan_code, scan_valid, frame_err
    );

    modport master (
        output ps2_clk, ps2_data,
        input  up, down, left, right, enter, space,
        input  scan_code, scan_valid, frame_err
    );
endinterface

// File: rtl/ttt_ps2_keys.sv
// PS/2 keyboard front end: conditions the raw lines, receives device-to-host frames and
// turns set-2 make/break codes into held-key levels for the tic-tac-toe controller.
module ttt_ps2_keys #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           reset_n,
    ttt_ps2_keys_if.slave  bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // Odd parity holds when the data byte plus parity bit has an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic          ck_s1_q, ck_s2_q, dt_s1_q, dt_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          up_q, up_d, down_q, down_d, left_q, left_d;
    logic          right_q, right_d, enter_q, enter_d, space_q, space_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          scan_valid_q, scan_valid_d, frame_err_q, frame_err_d;
    logic          fall_s, byte_ok_s, err_s;

    // Glitch filter on the synchronised clock; the falling edge is the cycle the filter drops.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = {FW{1'b0}};
        if (ck_s2_q != filt_q) begin
            if (flt_cnt_q == FLT_MAX) begin
                filt_d    = ~filt_q;
                flt_cnt_d = {FW{1'b0}};
            end else begin
                flt_cnt_d = flt_cnt_q + {{(FW-1){1'b0}}, 1'b1};
            end
        end else begin
            flt_cnt_d = {FW{1'b0}};
        end
        fall_s = filt_q & ~filt_d;
    end

    // Byte receiver with inter-edge timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = {TW{1'b0}};
        byte_ok_s = 1'b0;
        err_s     = 1'b0;
        if (state_q != RX_IDLE && !fall_s && to_cnt_q == TO_MAX) begin
            state_d = RX_IDLE;
            err_s   = 1'b1;
        end else if (state_q != RX_IDLE && !fall_s) begin
            to_cnt_d = to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end else if (fall_s) begin
            case (state_q)
                RX_IDLE: begin
                    if (dt_s2_q == 1'b0) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_d   = {dt_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        state_d = RX_DATA;
                    end
                end
                RX_PARITY: begin
                    par_d   = dt_s2_q;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (dt_s2_q == 1'b1 && odd_parity_ok(shift_q, par_q)) begin
                        byte_ok_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end else begin
            to_cnt_d = {TW{1'b0}};
        end
    end

    // Set-2 decoder: prefix flags and held-key levels.
    always_comb begin
        ext_d        = ext_q;
        brk_d        = brk_q;
        up_d         = up_q;
        down_d       = down_q;
        left_d       = left_q;
        right_d      = right_q;
        enter_d      = enter_q;
        space_d      = space_q;
        scan_code_d  = scan_code_q;
        scan_valid_d = byte_ok_s;
        frame_err_d  = err_s;
        if (err_s) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok_s) begin
            scan_code_d = shift_q;
            case (shift_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'hE1: ext_d = ext_q;
                default: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    case (shift_q)
                        8'h75: if (ext_q) up_d    = ~brk_q; else up_d    = up_q;
                        8'h72: if (ext_q) down_d  = ~brk_q; else down_d  = down_q;
                        8'h6B: if (ext_q) left_d  = ~brk_q; else left_d  = left_q;
                        8'h74: if (ext_q) right_d = ~brk_q; else right_d = right_q;
                        8'h5A: enter_d = ~brk_q;
                        8'h29: if (!ext_q) space_d = ~brk_q; else space_d = space_q;
                        default: up_d = up_q;
                    endcase
                end
            endcase
        end else begin
            scan_code_d = scan_code_q;
        end
    end

    // All state, with synchronous active-low reset returning the bus view to idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ck_s1_q      <= 1'b1;
            ck_s2_q      <= 1'b1;
            dt_s1_q      <= 1'b1;
            dt_s2_q      <= 1'b1;
            filt_q       <= 1'b1;
            flt_cnt_q    <= {FW{1'b0}};
            state_q      <= RX_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            to_cnt_q     <= {TW{1'b0}};
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            enter_q      <= 1'b0;
            space_q      <= 1'b0;
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            ck_s1_q      <= bus.ps2_clk;
            ck_s2_q      <= ck_s1_q;
            dt_s1_q      <= bus.ps2_data;
            dt_s2_q      <= dt_s1_q;
            filt_q       <= filt_d;
            flt_cnt_q    <= flt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            up_q         <= up_d;
            down_q       <= down_d;
            left_q       <= left_d;
            right_q      <= right_d;
            enter_q      <= enter_d;
            space_q      <= space_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.up         = up_q;
    assign bus.down       = down_q;
    assign bus.left       = left_q;
    assign bus.right      = right_q;
    assign bus.enter      = enter_q;
    assign bus.space      = space_q;
    assign bus.scan_code  = scan_code_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ttt_ps2_keys.sv
// Directed bench for ttt_ps2_keys: bit-banged PS/2 frames with hand-computed key levels.
module tb_ttt_ps2_keys;
    localparam int HALF = 20;
    localparam int TO   = 2000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   tests   = 0;
    int   fails   = 0;
    int   sv_cnt  = 0;
    int   fe_cnt  = 0;
    int   left_fall = 0;
    logic left_prev = 1'b0;
    int   sv0, fe0, lf0;

    ttt_ps2_keys_if bus ();

    ttt_ps2_keys #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #20 clk = ~clk;

    // Pulse and glitch counters, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (bus.scan_valid) sv_cnt++;
        if (bus.frame_err)  fe_cnt++;
        if (left_prev && !bus.left) left_fall++;
        left_prev = bus.left;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = fr[i];
            idle(HALF);
            bus.ps2_clk = 1'b0;
            idle(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        send_bits({1'b1, par, b, 1'b0}, 11);
        idle(HALF);
    endtask

    function automatic logic [31:0] keys();
        return {26'd0, bus.up, bus.down, bus.left, bus.right, bus.enter, bus.space};
    endfunction

    function automatic logic [31:0] all_out();
        return {16'd0, bus.up, bus.down, bus.left, bus.right, bus.enter, bus.space,
                bus.scan_code, bus.scan_valid, bus.frame_err};
    endfunction

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        idle(4);
        check_eq("reset_outputs", all_out(), 32'd0);
        reset_n = 1'b1;
        idle(10);

        // 1: space make and break
        sv0 = sv_cnt;
        send_byte(8'h29, 1'b0);
        check_eq("t1_code", 32'(bus.scan_code), 32'h29);
        check_eq("t1_sv", 32'(sv_cnt - sv0), 32'd1);
        check_eq("t1_space_make", keys(), 32'b000001);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h29, 1'b0);
        check_eq("t1_space_break", keys(), 32'b000000);
        check_eq("t1_sv_total", 32'(sv_cnt - sv0), 32'd3);

        // 2: extended arrows and enter
        send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
        check_eq("t2_up_make", keys(), 32'b100000);
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
        check_eq("t2_up_break", keys(), 32'b000000);
        send_byte(8'h75, 1'b0);
        check_eq("t2_plain_75", keys(), 32'b000000);
        check_eq("t2_plain_code", 32'(bus.scan_code), 32'h75);
        send_byte(8'hE0, 1'b0); send_byte(8'h5A, 1'b0);
        check_eq("t2_enter_make", keys(), 32'b000010);
        send_byte(8'hF0, 1'b0); send_byte(8'h5A, 1'b0);
        check_eq("t2_enter_break", keys(), 32'b000000);
        send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
        check_eq("t2_down_right", keys(), 32'b010100);

        // 3: parity error clears the break prefix
        sv0 = sv_cnt; fe0 = fe_cnt;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h5A, 1'b1);
        check_eq("t3_fe", 32'(fe_cnt - fe0), 32'd1);
        check_eq("t3_sv", 32'(sv_cnt - sv0), 32'd1);
        check_eq("t3_code", 32'(bus.scan_code), 32'hF0);
        send_byte(8'h5A, 1'b0);
        check_eq("t3_enter_make", keys(), 32'b010110);

        // 4: truncated frame times out once
        fe0 = fe_cnt;
        send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 6);
        idle(TO + 100);
        check_eq("t4_timeout_fe", 32'(fe_cnt - fe0), 32'd1);
        send_byte(8'h29, 1'b0);
        check_eq("t4_space", keys(), 32'b010111);
        check_eq("t4_fe_after", 32'(fe_cnt - fe0), 32'd1);

        // 5: independent keys and typematic repeats
        send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
        check_eq("t5_left_make", keys(), 32'b011111);
        send_byte(8'hF0, 1'b0); send_byte(8'h29, 1'b0);
        check_eq("t5_space_break", keys(), 32'b011110);
        lf0 = left_fall;
        for (int r = 0; r < 3; r++) begin
            send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
            check_eq("t5_left_repeat", 32'(bus.left), 32'd1);
        end
        check_eq("t5_left_no_glitch", 32'(left_fall - lf0), 32'd0);

        // 6: clock glitch rejected, then reset mid-frame
        sv0 = sv_cnt; fe0 = fe_cnt;
        bus.ps2_clk = 1'b0;
        idle(1);
        bus.ps2_clk = 1'b1;
        idle(20);
        check_eq("t6_glitch_fe", 32'(fe_cnt - fe0), 32'd0);
        check_eq("t6_glitch_sv", 32'(sv_cnt - sv0), 32'd0);
        send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
        check_eq("t6_up_make", keys(), 32'b111110);
        fe0 = fe_cnt;
        send_bits({1'b1, 1'b0, 8'h6B, 1'b0}, 4);
        reset_n = 1'b0;
        idle(1);
        check_eq("t6_reset_outputs", all_out(), 32'd0);
        idle(3);
        reset_n = 1'b1;
        idle(10);
        send_byte(8'h29, 1'b0);
        check_eq("t6_after_reset_keys", keys(), 32'b000001);
        check_eq("t6_after_reset_code", 32'(bus.scan_code), 32'h29);
        check_eq("t6_no_fe", 32'(fe_cnt - fe0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
